// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_unit
// Purpose  : MIPS fetch-stage program counter with redirects, fetch
//            handshake, stall, halt/resume and a one-cycle post-reset hold.
//            Optional macro PC_ALIGN_CHECK_EN traps misaligned redirect targets.
// Revision : 1.0 - initial release
// ============================================================================
module pc_unit #(
    parameter int          WIDTH        = 32,
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          INSTR_BYTES  = 4,
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0180
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             fetch_ready,
    input  logic             branch_taken,
    input  logic [15:0]      branch_offset,
    input  logic             jump,
    input  logic [25:0]      jump_index,
    input  logic             jump_reg,
    input  logic [WIDTH-1:0] jr_target,
    input  logic             halt,
    input  logic             resume,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic             pc_valid,
    output logic             halted
`ifdef PC_ALIGN_CHECK_EN
    ,
    output logic             misaligned
`endif
);

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] w_pc_nxt;
    logic [WIDTH-1:0] w_branch_off;
    logic [WIDTH-1:0] w_branch_target;
    logic [WIDTH-1:0] w_jump_target;
    logic [WIDTH-1:0] w_target;
    logic             w_redirect;
    logic             w_mis_nxt;

    assign pc       = r_pc;
    assign pc_plus4 = r_pc + WIDTH'(INSTR_BYTES);
    assign pc_valid = (r_state == ST_RUN);
    assign halted   = (r_state == ST_HALT);

    // Word offset sign-extended and scaled to bytes; sums wrap at WIDTH bits.
    assign w_branch_off    = {{(WIDTH-18){branch_offset[15]}}, branch_offset, 2'b00};
    assign w_branch_target = pc_plus4 + w_branch_off;
    assign w_jump_target   = {pc_plus4[WIDTH-1:28], jump_index, 2'b00};
    assign w_redirect      = jump_reg | jump | branch_taken;

    always_comb begin
        w_target = w_branch_target;
        if (jump_reg) begin
            w_target = jr_target;
        end else if (jump) begin
            w_target = w_jump_target;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_mis_nxt   = 1'b0;
        case (r_state)
            ST_HOLD: begin
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (w_redirect) begin
                    w_pc_nxt = w_target;
`ifdef PC_ALIGN_CHECK_EN
                    if (w_target[1:0] != 2'b00) begin
                        w_pc_nxt  = WIDTH'(EXC_VECTOR);
                        w_mis_nxt = 1'b1;
                    end
`endif
                end else if (!stall && fetch_ready) begin
                    w_pc_nxt = pc_plus4;
                end
                // The PC update above still lands on the halting edge.
                if (halt) begin
                    w_state_nxt = ST_HALT;
                end
            end
            ST_HALT: begin
                if (resume) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_HOLD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_HOLD;
            r_pc    <= WIDTH'(RESET_VECTOR);
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    logic r_misaligned;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_misaligned <= 1'b0;
        end else begin
            r_misaligned <= w_mis_nxt;
        end
    end

    assign misaligned = r_misaligned;
`else
    logic w_unused_align;
    assign w_unused_align = ^{EXC_VECTOR, w_mis_nxt};
`endif

endmodule
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_unit
// Purpose  : Self-checking bench for pc_unit (vector table plus scoreboard).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_unit;

    typedef struct {
        logic        stall;
        logic        fetch_ready;
        logic        branch_taken;
        logic [15:0] branch_offset;
        logic        jump;
        logic [25:0] jump_index;
        logic        jump_reg;
        logic [31:0] jr_target;
        logic        halt;
        logic        resume;
        logic [31:0] exp_pc;
        logic        exp_valid;
        logic        exp_halted;
        logic        exp_mis;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic        valid;
        logic        halted;
        logic        mis;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        fetch_ready;
    logic        branch_taken;
    logic [15:0] branch_offset;
    logic        jump;
    logic [25:0] jump_index;
    logic        jump_reg;
    logic [31:0] jr_target;
    logic        halt;
    logic        resume;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        pc_valid;
    logic        halted;
    logic        misaligned;

    int total = 0;
    int bad   = 0;

    vec_t vecs[$];
    exp_t sb[$];

    always #5 clk = ~clk;

    pc_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .fetch_ready   (fetch_ready),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .jump          (jump),
        .jump_index    (jump_index),
        .jump_reg      (jump_reg),
        .jr_target     (jr_target),
        .halt          (halt),
        .resume        (resume),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .pc_valid      (pc_valid),
        .halted        (halted)
`ifdef PC_ALIGN_CHECK_EN
        ,
        .misaligned    (misaligned)
`endif
    );

`ifndef PC_ALIGN_CHECK_EN
    assign misaligned = 1'b0;
`endif

    function automatic vec_t mk(logic st, logic fr, logic br, logic [15:0] off,
                                logic j, logic [25:0] idx, logic jr, logic [31:0] jt,
                                logic h, logic r, logic [31:0] epc, logic ev,
                                logic eh, logic em);
        vec_t v;
        v.stall = st;  v.fetch_ready = fr; v.branch_taken = br; v.branch_offset = off;
        v.jump = j;    v.jump_index = idx; v.jump_reg = jr;     v.jr_target = jt;
        v.halt = h;    v.resume = r;       v.exp_pc = epc;      v.exp_valid = ev;
        v.exp_halted = eh; v.exp_mis = em;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        stall = v.stall;   fetch_ready = v.fetch_ready; branch_taken = v.branch_taken;
        branch_offset = v.branch_offset; jump = v.jump; jump_index = v.jump_index;
        jump_reg = v.jump_reg; jr_target = v.jr_target; halt = v.halt; resume = v.resume;
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare after the edge.
    task automatic step(input string tag, input vec_t v);
        exp_t e;
        exp_t got;
        drive(v);
        e.pc = v.exp_pc; e.valid = v.exp_valid; e.halted = v.exp_halted; e.mis = v.exp_mis;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s scoreboard: got empty queue expected an entry", tag);
        end else begin
            got = sb.pop_front();
            chk({tag, " pc"},       pc,                 got.pc);
            chk({tag, " pc_plus4"}, pc_plus4,           got.pc + 32'd4);
            chk({tag, " pc_valid"}, {31'd0, pc_valid},  {31'd0, got.valid});
            chk({tag, " halted"},   {31'd0, halted},    {31'd0, got.halted});
`ifdef PC_ALIGN_CHECK_EN
            chk({tag, " misaligned"}, {31'd0, misaligned}, {31'd0, got.mis});
`endif
        end
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] mis_pc0;
        logic [31:0] mis_pc1;
        logic        mis_flag;
`ifdef PC_ALIGN_CHECK_EN
        mis_pc0 = 32'h0000_0180; mis_pc1 = 32'h0000_0184; mis_flag = 1'b1;
`else
        mis_pc0 = 32'h0000_0102; mis_pc1 = 32'h0000_0106; mis_flag = 1'b0;
`endif
        //                 st fr br off       j  idx         jr jt            h  r  exp_pc          v  hl mis
        vecs.push_back(mk(0, 0, 1, 16'h0003, 1, 26'h0000FF, 1, 32'h0000_1234, 1, 0, 32'h0000_0000, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 26'h0,      0, 32'h0,         0, 0, 32'h0000_0004, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 26'h0,      0, 32'h0,         0, 0, 32'h0000_0008, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 26'h0,      0, 32'h0,         0, 0, 32'h0000_000C, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 26'h0,      0, 32'h0,         0, 0, 32'h0000_0010, 1, 0, 0));
        for (int k = 0; k < 3; k++)
            vecs.push_back(mk(1, 1, 0, 16'h0000, 0, 26'h0,  0, 32'h0,         0, 0, 32'h0000_0010, 1, 0, 0));
        for (int k = 0; k < 2; k++)
            vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 26'h0,  0, 32'h0,         0, 0, 32'h0000_0010, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 26'h0,      0, 32'h0,         0, 0, 32'h0000_0014, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 26'h000040, 0, 32'h0,         0, 0, 32'h0000_0100, 1, 0, 0));
        vecs.push_back(mk(1, 1, 1, 16'hFFFE, 0, 26'h0,      0, 32'h0,         0, 0, 32'h0000_00FC, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 1, 26'h100000, 0, 32'h0,         0, 0, 32'h0040_0000, 1, 0, 0));
        vecs.push_back(mk(0, 1, 1, 16'h7FFF, 1, 26'h3FFFFFF,1, 32'h0000_0080, 0, 0, 32'h0000_0080, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 1, 26'h000010, 0, 32'h0,         0, 0, 32'h0000_0040, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 16'h0004, 0, 26'h0,      0, 32'h0,         0, 0, 32'h0000_0054, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 26'h0,      1, 32'hFFFF_FFF8, 0, 0, 32'hFFFF_FFF8, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 26'h0,      0, 32'h0,         0, 0, 32'hFFFF_FFFC, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 26'h0,      0, 32'h0,         1, 0, 32'h0000_0000, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 26'h0,      1, 32'h0000_0500, 1, 0, 32'h0000_0000, 0, 1, 0));
        vecs.push_back(mk(0, 1, 1, 16'h0010, 0, 26'h0,      0, 32'h0,         0, 0, 32'h0000_0000, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 1, 26'h000123, 0, 32'h0,         1, 0, 32'h0000_0000, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 26'h0,      0, 32'h0,         0, 0, 32'h0000_0000, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 26'h0,      0, 32'h0,         1, 1, 32'h0000_0000, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 26'h0,      0, 32'h0,         0, 0, 32'h0000_0004, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 26'h0,      1, 32'h0000_0200, 1, 0, 32'h0000_0200, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 26'h0,      0, 32'h0,         0, 1, 32'h0000_0200, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 26'h0,      1, 32'h0000_0102, 0, 0, mis_pc0,       1, 0, mis_flag));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 26'h0,      0, 32'h0,         0, 0, mis_pc1,       1, 0, 0));

        drive(mk(0, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0));
        rst_n = 1'b0;
        #12;
        chk("reset pc",         pc,                     32'h0);
        chk("reset pc_plus4",   pc_plus4,               32'h4);
        chk("reset pc_valid",   {31'd0, pc_valid},      32'd0);
        chk("reset halted",     {31'd0, halted},        32'd0);
        chk("reset misaligned", {31'd0, misaligned},    32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("hold pc_valid", {31'd0, pc_valid}, 32'd0);
        chk("hold pc",       pc,                32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            step($sformatf("v%0d", i), vecs[i]);
        end

        // Asynchronous reset landing between edges while a branch is requested.
        drive(mk(0, 1, 1, 16'h0004, 0, 26'h0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async pc",       pc,                32'h0);
        chk("async pc_valid", {31'd0, pc_valid}, 32'd0);
        chk("async halted",   {31'd0, halted},   32'd0);
        @(posedge clk);
        #1;
        chk("async held pc",       pc,                32'h0);
        chk("async held pc_valid", {31'd0, pc_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step("post-reset hold", mk(0, 1, 1, 16'h0004, 0, 26'h0, 0, 32'h0, 0, 0, 32'h0000_0000, 1, 0, 0));
        step("post-reset branch", mk(0, 1, 1, 16'h0004, 0, 26'h0, 0, 32'h0, 0, 0, 32'h0000_0014, 1, 0, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
